// File: rtl/link_pkg.sv
// Shared encodings, rail indices and transmitter state type for the dual-rail link.
package link_pkg;

    localparam logic [15:0] ENC_TP = "TP";
    localparam logic [15:0] ENC_FP = "FP";

    localparam int RAIL_F = 0;
    localparam int RAIL_T = 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH_WAIT,
        RTZ_WAIT
    } tx_state_t;

endpackage

// File: rtl/link_intf.sv
// Dual-rail link: data[rail][bit] flows source -> sink, ack flows back.
interface link_intf #(
    parameter int WIDTH = 1
);
    logic [1:0][WIDTH-1:0] data;
    logic                  ack;

    modport source (output data, input ack);
    modport sink   (input data, output ack);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count and a combinational head word.
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sync_link_tx.sv
// Clocked producer: buffers valid/ready words and launches them as dual-rail tokens
// using either two-phase (TP) or four-phase return-to-zero (FP) signalling.
module sync_link_tx
    import link_pkg::*;
#(
    parameter logic [15:0] ENC         = "TP",
    parameter int          WIDTH       = 1,
    parameter int          DEPTH       = 4,
    parameter int          SYNC_STAGES = 2,
    localparam int         CW          = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    link_intf.source         out,
    output logic             busy,
    output logic [15:0]      tokens_sent
);
    if (!(ENC == ENC_TP || ENC == ENC_FP)) begin : g_enc_check
        $error("sync_link_tx: ENC must be \"TP\" or \"FP\"");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_link_tx: DEPTH must be a power of two and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("sync_link_tx: SYNC_STAGES must be at least 2");
    end

    localparam bit IS_TP = (ENC == ENC_TP);

    tx_state_t             state, state_next;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                  a_s;
    logic                  ack_phase;
    logic [1:0][WIDTH-1:0] rails, rails_next;
    logic                  complete;
    logic                  rst_done;
    logic                  push;
    logic [WIDTH-1:0]      head;
    logic [CW-1:0]         fifo_count;
    logic                  full;
    logic                  empty;

    // in_ready stays low until the first edge after reset release.
    assign in_ready = rst_done && !full;
    assign push     = in_valid && in_ready;
    assign a_s      = ack_sync[SYNC_STAGES-1];
    assign out.data = rails;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (complete),
        .wr_data (in_data),
        .rd_data (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        rails_next = rails;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        rails_next[head[i]][i] = IS_TP ? ~rails[head[i]][i] : 1'b1;
                    end
                    state_next = LAUNCH_WAIT;
                end
            end
            LAUNCH_WAIT: begin
                if (IS_TP) begin
                    if (a_s != ack_phase) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (a_s) begin
                    rails_next = '0;
                    state_next = RTZ_WAIT;
                end
            end
            RTZ_WAIT: begin
                if (!a_s) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rails       <= '0;
            ack_sync    <= '0;
            ack_phase   <= 1'b0;
            tokens_sent <= '0;
            rst_done    <= 1'b0;
        end else begin
            state    <= state_next;
            rails    <= rails_next;
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], out.ack};
            rst_done <= 1'b1;
            if (complete) begin
                tokens_sent <= tokens_sent + 16'd1;
                if (IS_TP) ack_phase <= ~ack_phase;
            end
        end
    end

endmodule

// File: tb/tb_sync_link_tx.sv
// Bench for sync_link_tx: directed protocol scenarios plus random traffic checked by
// bench-side receivers that decode tokens from the rails and compare to pushed words.
module tb_sync_link_tx;
    import link_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    link_intf #(.WIDTH(1)) tp_link ();
    link_intf #(.WIDTH(2)) fp_link ();

    logic [0:0]  tp_in_data = '0;
    logic        tp_in_valid = 1'b0;
    logic        tp_in_ready;
    logic        tp_busy;
    logic [15:0] tp_tokens;
    logic [1:0]  fp_in_data = '0;
    logic        fp_in_valid = 1'b0;
    logic        fp_in_ready;
    logic        fp_busy;
    logic [15:0] fp_tokens;

    logic tp_man_ack = 1'b0;
    logic tp_auto_ack = 1'b0;
    logic fp_man_ack = 1'b0;
    logic fp_auto_ack = 1'b0;
    assign tp_link.ack = tp_man_ack ^ tp_auto_ack;
    assign fp_link.ack = fp_man_ack | fp_auto_ack;

    sync_link_tx #(.ENC("TP"), .WIDTH(1), .DEPTH(4), .SYNC_STAGES(2)) u_tp (
        .clk (clk), .rst (rst), .in_data (tp_in_data), .in_valid (tp_in_valid),
        .in_ready (tp_in_ready), .out (tp_link), .busy (tp_busy), .tokens_sent (tp_tokens)
    );

    sync_link_tx #(.ENC("FP"), .WIDTH(2), .DEPTH(4), .SYNC_STAGES(2)) u_fp (
        .clk (clk), .rst (rst), .in_data (fp_in_data), .in_valid (fp_in_valid),
        .in_ready (fp_in_ready), .out (fp_link), .busy (fp_busy), .tokens_sent (fp_tokens)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Receivers: expected words queued by the pushers, decoded words come off the rails.
    logic [0:0] tp_q[$];
    logic [1:0] fp_q[$];
    bit         tp_auto = 0;
    bit         fp_auto = 0;
    logic [1:0] tp_seen = '0;
    logic [1:0] tp_diff;
    bit         tp_pending = 0;
    int         tp_trans = 0;
    bit         fp_got = 0;
    int         fp_bad = 0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            tp_auto_ack = 1'b0;
            tp_seen     = '0;
            tp_pending  = 0;
            tp_trans    = 0;
        end else if (tp_auto) begin
            if (tp_link.data != tp_seen) begin
                tp_diff = tp_link.data ^ tp_seen;
                tp_seen = tp_link.data;
                tp_trans++;
                check("tp_single_rail", 32'(tp_diff == 2'b01 || tp_diff == 2'b10), 1);
                if (tp_q.size() == 0) check("tp_unexpected_token", 1, 0);
                else check("tp_word", 32'(tp_diff[RAIL_T]), 32'(tp_q.pop_front()));
                tp_pending = 1;
            end else if (tp_pending && $urandom_range(1) == 1) begin
                tp_auto_ack = ~tp_auto_ack;
                tp_pending  = 0;
            end
        end
    end

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            fp_auto_ack = 1'b0;
            fp_got      = 0;
        end else begin
            if ((fp_link.data[RAIL_F] & fp_link.data[RAIL_T]) != 2'b00) fp_bad++;
            if (fp_auto) begin
                if (!fp_got && (fp_link.data[RAIL_F] | fp_link.data[RAIL_T]) == 2'b11) begin
                    if (fp_q.size() == 0) check("fp_unexpected_token", 1, 0);
                    else check("fp_word", 32'(fp_link.data[RAIL_T]), 32'(fp_q.pop_front()));
                    fp_got = 1;
                end else if (fp_got && !fp_auto_ack && $urandom_range(1) == 1) begin
                    fp_auto_ack = 1'b1;
                end else if (fp_got && fp_auto_ack && fp_link.data == '0 && $urandom_range(1) == 1) begin
                    fp_auto_ack = 1'b0;
                    fp_got      = 0;
                end
            end
        end
    end

    // All stimulus tasks start and end #1 after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        tp_in_valid = 1'b0;
        fp_in_valid = 1'b0;
        tp_man_ack  = 1'b0;
        fp_man_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic tp_push(input logic [0:0] d);
        tp_in_data  = d;
        tp_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tp_in_ready) begin
                @(posedge clk);
                #1 tp_in_valid = 1'b0;
                if (tp_auto) tp_q.push_back(d);
                return;
            end
        end
        tp_in_valid = 1'b0;
        check("tp_push_timeout", 0, 1);
    endtask

    task automatic fp_push(input logic [1:0] d);
        fp_in_data  = d;
        fp_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fp_in_ready) begin
                @(posedge clk);
                #1 fp_in_valid = 1'b0;
                if (fp_auto) fp_q.push_back(d);
                return;
            end
        end
        fp_in_valid = 1'b0;
        check("fp_push_timeout", 0, 1);
    endtask

    task automatic tp_drain();
        for (int i = 0; i < 500 && tp_busy; i++) @(posedge clk);
        #1 check("tp_drain", 32'(tp_busy), 0);
    endtask

    task automatic fp_drain();
        for (int i = 0; i < 500 && fp_busy; i++) @(posedge clk);
        #1 check("fp_drain", 32'(fp_busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset values and in_ready release timing
        repeat (2) @(posedge clk);
        #1;
        check("rst_tp_data", 32'(tp_link.data), 0);
        check("rst_fp_data", 32'(fp_link.data), 0);
        check("rst_in_ready", 32'(tp_in_ready), 0);
        check("rst_busy", 32'(tp_busy), 0);
        check("rst_tokens", 32'(tp_tokens), 0);
        rst = 1'b0;
        #1 check("in_ready_before_edge", 32'(tp_in_ready), 0);
        @(posedge clk);
        #1 check("in_ready_after_edge", 32'(tp_in_ready), 1);

        // TP single token: launch at N+1, ack toggled after N+3 completes at N+6
        tp_in_data  = 1'b1;
        tp_in_valid = 1'b1;
        @(posedge clk);
        #1 tp_in_valid = 1'b0;
        check("tp_no_launch_at_N", 32'(tp_link.data), 0);
        check("tp_busy_after_push", 32'(tp_busy), 1);
        @(posedge clk);
        #1 check("tp_launch_rails", 32'(tp_link.data), 32'b10);
        check("tp_busy_launched", 32'(tp_busy), 1);
        repeat (2) @(posedge clk);
        #1 tp_man_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("tp_tokens_N5", 32'(tp_tokens), 0);
        @(posedge clk);
        #1 check("tp_tokens_N6", 32'(tp_tokens), 1);
        check("tp_idle_N6", 32'(tp_busy), 0);
        check("tp_rails_held", 32'(tp_link.data), 32'b10);

        // TP back-to-back 0,0,1 with automatic receiver
        do_reset();
        tp_auto = 1;
        tp_push(1'b0);
        tp_push(1'b0);
        tp_push(1'b1);
        tp_drain();
        check("tp_seq_tokens", 32'(tp_tokens), 3);
        check("tp_seq_transitions", 32'(tp_trans), 3);
        check("tp_seq_queue", 32'(tp_q.size()), 0);
        check("tp_seq_rails", 32'(tp_link.data), 32'b10);
        tp_auto = 0;

        // TP FIFO fill without ack, then a single ack frees exactly one slot
        do_reset();
        tp_in_data  = 1'b1;
        tp_in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tp_in_ready) acc++;
            @(posedge clk);
            #1;
        end
        check("tp_fill_accepts", 32'(acc), 4);
        check("tp_fill_not_ready", 32'(tp_in_ready), 0);
        tp_man_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tp_in_ready) acc++;
            @(posedge clk);
            #1;
        end
        tp_in_valid = 1'b0;
        check("tp_refill_accepts", 32'(acc), 5);
        check("tp_refill_not_ready", 32'(tp_in_ready), 0);
        check("tp_refill_tokens", 32'(tp_tokens), 1);
        check("tp_second_launch_rails", 32'(tp_link.data), 0);

        // FP WIDTH=2 token 2'b10 through launch, return-to-zero and completion
        do_reset();
        fp_push(2'b10);
        @(posedge clk);
        #1 check("fp_launch_rails", 32'(fp_link.data), 32'b1001);
        fp_man_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("fp_rtz_rails", 32'(fp_link.data), 0);
        check("fp_rtz_busy", 32'(fp_busy), 1);
        check("fp_rtz_tokens", 32'(fp_tokens), 0);
        fp_man_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("fp_done_tokens", 32'(fp_tokens), 1);
        check("fp_done_busy", 32'(fp_busy), 0);
        check("fp_done_ready", 32'(fp_in_ready), 1);

        // Reset asserted mid-handshake in FP LAUNCH_WAIT
        fp_push(2'b01);
        @(posedge clk);
        #1 check("fp_launch_01", 32'(fp_link.data), 32'b0110);
        #2 rst = 1'b1;
        #1 check("fp_midrst_rails", 32'(fp_link.data), 0);
        check("fp_midrst_tokens", 32'(fp_tokens), 0);
        check("fp_midrst_busy", 32'(fp_busy), 0);
        check("fp_midrst_ready", 32'(fp_in_ready), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("fp_postrst_ready", 32'(fp_in_ready), 1);
        fp_auto = 1;
        fp_push(2'b11);
        fp_drain();
        check("fp_postrst_tokens", 32'(fp_tokens), 1);
        check("fp_postrst_queue", 32'(fp_q.size()), 0);

        // Random traffic on both encodings with randomly delayed acks
        do_reset();
        tp_auto = 1;
        fp_auto = 1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    tp_push(1'($urandom));
                    repeat ($urandom_range(2)) @(posedge clk);
                    #0;
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    fp_push(2'($urandom));
                    repeat ($urandom_range(2)) @(posedge clk);
                    #0;
                end
            end
        join
        tp_drain();
        fp_drain();
        check("rand_tp_tokens", 32'(tp_tokens), 24);
        check("rand_fp_tokens", 32'(fp_tokens), 24);
        check("rand_tp_queue", 32'(tp_q.size()), 0);
        check("rand_fp_queue", 32'(fp_q.size()), 0);
        check("fp_rail_exclusive", 32'(fp_bad), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_link_tx.md
Name: sync_link_tx

Overview:
- Clocked producer stage that converts valid/ready words into dual-rail link tokens, driving one `link_intf` source.
- Sits directly upstream of the asynchronous arithmetic cells, for example feeding the `a`, `b` and `c_in` links of the full adder. One instance is used per input link.
- Buffers words in a small FIFO and runs the link handshake in the encoding selected by ENC.

Parameters:
- ENC, "TP": link encoding. "TP" is two-phase dual-rail (transition signalling); "FP" is four-phase dual-rail (return-to-zero). Any other value is a elaboration-time $error.
- WIDTH, 1: data bits per token; must equal the `link_intf` data width.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- SYNC_STAGES, 2: flops in the ack synchronizer; at least 2.

Ports:
- clk  input  1  sole clock.
- rst  input  1  reset, asynchronous and active-high.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word.
- out  link_intf source modport  -  drives data[rail][bit] (rail 0 = false, rail 1 = true) and samples ack.
- busy  output  1  token in flight, or FIFO not empty.
- tokens_sent  output  16  count of completed handshakes; wraps at 2^16.

Behaviour:
- Reset (async assert, sync release):
  - out.data all 0, in_ready 0, busy 0, tokens_sent 0, FIFO empty.
  - Ack synchronizer flops and the internal ack_phase reference cleared to 0.
  - in_ready rises on the first clk edge after rst deasserts.
- Accept: a word is written when in_valid && in_ready at a clk edge.
- in_ready = !full, from the registered count.
  - A pop in the same cycle does not enable a push when the FIFO is full.
  - Push and pop in the same cycle when not full/empty leaves the count unchanged.
- The head word stays in the FIFO until its handshake completes (popped on completion).
- FSM states: IDLE, LAUNCH_WAIT, RTZ_WAIT (FP only).
- IDLE, FIFO not empty, at edge E: for each bit i, drive the rail selected by head[i] at E.
  - TP: toggle data[head[i]][i].
  - FP: set data[head[i]][i] = 1.
  - Then go to LAUNCH_WAIT.
  - Latency: a word accepted into an empty FIFO at edge N launches at edge N+1.
- LAUNCH_WAIT: a_s is the synchronized ack, delayed SYNC_STAGES edges.
  - TP: when a_s != ack_phase, toggle ack_phase, pop, increment tokens_sent, go to IDLE.
  - FP: when a_s == 1, clear all rails to 0 and go to RTZ_WAIT.
- RTZ_WAIT (FP): when a_s == 0, pop, increment tokens_sent, go to IDLE.
- Next-token timing:
  - The next launch happens no earlier than the edge after the return to IDLE.
  - Rails change only on clk edges, and at most one rail per bit changes per launch.
- Rail invariants:
  - TP: the false and true rails of a bit never both toggle in one launch.
  - FP: data[0][i] and data[1][i] are never both 1.
- Ack glitches: an ack change that reverts before being synchronized is not required to be detected. The downstream stage must hold ack stable per protocol.
- Reset mid-handshake: rails are forced to 0 immediately and the token is lost.
  - Downstream must share rst. In TP, ack_phase 0 then matches the downstream ack reset value.
- busy = (state != IDLE) || !empty.

Decomposition:
- Package link_pkg holds:
  - encoding constants ENC_TP = "TP" and ENC_FP = "FP";
  - RAIL_F = 0 and RAIL_T = 1;
  - typedef tx_state_t {IDLE, LAUNCH_WAIT, RTZ_WAIT}.
- Sub-module sync_fifo (WIDTH, DEPTH) provides the registered count, full, empty and the head word read combinationally.
- The ack synchronizer is an inline shift register.

Test Plan:
- TP, WIDTH=1: push 1 at edge N.
  - Expect data[1][0] 0->1 at N+1, data[0][0] unchanged, busy=1.
  - Bench toggles ack at N+3: expect tokens_sent=1 by N+6, busy=0.
- TP, push 0,0,1 back-to-back, bench acks each launch.
  - Expect data[0][0] 0->1->0, then data[1][0] 0->1, tokens_sent=3.
  - Expect three single-rail transitions only.
- FP, WIDTH=2, push 2'b10.
  - Expect data[1][1]=1 and data[0][0]=1.
  - ack=1: rails all 0. ack=0: tokens_sent=1, ready for next word.
- DEPTH=4, bench never acks, hold in_valid high.
  - Expect exactly 4 words accepted and in_ready=0.
  - Then one ack toggle: expect one pop and in_ready=1 for one more accept.
- Assert rst during FP LAUNCH_WAIT.
  - Expect data all 0 asynchronously, tokens_sent=0, FIFO empty.
  - Expect normal operation after release.
- End-to-end: three TP instances feed the full adder `a`/`b`/`c_in`; push a=1, b=1, c_in=0.
  - Expect s token on rail 0 and c_out token on rail 1.
  - Each tx sees its ack toggle once.
